// File: rtl/rt_ibex_pcs_rf_writeback.sv
`default_nettype none
// ============================================================================
// Module   : rt_ibex_pcs_rf_writeback
// Brief    : Restores a saved PCS context into the Ibex register file on mret.
//            The context word is captured from the LIFO, then the registers
//            are written back one slot per granted cycle while the core is
//            stalled. The block also tracks the nesting depth of saved
//            contexts and flags overflow, underflow and protocol errors.
// Revision : 1.0 - initial release
// ============================================================================
module rt_ibex_pcs_rf_writeback #(
  parameter int unsigned NrSavedRegs    = 9,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxDepth       = 8,
  // Slot i address lives in bits [5*i +: 5]; slot 0 is the lowest field.
  parameter logic [NrSavedRegs*5-1:0] SlotAddr = {5'd14, 5'd13, 5'd12, 5'd11,
                                                  5'd10, 5'd7, 5'd6, 5'd5, 5'd1},
  parameter int unsigned RestoreTimeout = 4,
  localparam int unsigned DepthW = $clog2(MaxDepth + 1),
  localparam int unsigned SlotW  = (NrSavedRegs > 1) ? $clog2(NrSavedRegs) : 1,
  localparam int unsigned TimerW = $clog2(RestoreTimeout + 1)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  irq_ack_i,
  input  logic                                  next_mret_i,
  input  logic                                  restore_en_i,
  input  logic [NrSavedRegs-1:0][DataWidth-1:0] restore_data_i,
  output logic                                  rf_we_o,
  output logic [4:0]                            rf_waddr_o,
  output logic [DataWidth-1:0]                  rf_wdata_o,
  input  logic                                  rf_wgnt_i,
  output logic                                  stall_o,
  output logic                                  done_o,
  output logic [DepthW-1:0]                     depth_o,
  output logic                                  overflow_o,
  output logic                                  underflow_o,
  output logic                                  err_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DATA = 2'd1,
    WRITE     = 2'd2,
    DONE      = 2'd3
  } state_e;

  state_e                                state_q, state_d;
  logic [DepthW-1:0]                     depth_q, depth_d;
  logic [SlotW-1:0]                      slot_q, slot_d;
  logic [TimerW-1:0]                     timer_q, timer_d;
  logic [NrSavedRegs-1:0][DataWidth-1:0] buf_q;

  logic                 capture;
  logic                 mret_req;
  logic                 mret_accept;
  logic                 underflow;
  logic                 overflow;
  logic                 stall;
  logic                 we;
  logic [4:0]           waddr;
  logic [DataWidth-1:0] wdata;
  logic                 done;
  logic                 err;

  // Unpack the flat address parameter into a per-slot lookup table.
  logic [4:0] slot_addr_tbl [NrSavedRegs];

  generate
    for (genvar g = 0; g < NrSavedRegs; g++) begin : g_slot_addr
      assign slot_addr_tbl[g] = SlotAddr[g*5 +: 5];
    end
  endgenerate

  // An mret only counts in IDLE and loses to a simultaneous interrupt ack,
  // mirroring the push-over-pop priority of the LIFO.
  assign mret_req    = (state_q == IDLE) && next_mret_i && !irq_ack_i;
  assign mret_accept = mret_req && (depth_q != '0);
  assign underflow   = mret_req && (depth_q == '0);
  assign overflow    = irq_ack_i && (depth_q == DepthW'(MaxDepth));

  // Nesting depth: acks are counted in every state; a full LIFO holds.
  always_comb begin
    depth_d = depth_q;
    if (irq_ack_i) begin
      if (!overflow) begin
        depth_d = depth_q + DepthW'(1);
      end
    end else if (mret_accept) begin
      depth_d = depth_q - DepthW'(1);
    end
  end

  // Restore sequencer: next state, slot/timer updates and raw outputs.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    timer_d = timer_q;
    capture = 1'b0;
    stall   = 1'b0;
    we      = 1'b0;
    waddr   = '0;
    wdata   = '0;
    done    = 1'b0;
    err     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Context data with no pending restore is dropped and flagged.
        if (restore_en_i) begin
          err = 1'b1;
        end
        if (mret_accept) begin
          stall   = 1'b1;
          timer_d = '0;
          state_d = WAIT_DATA;
        end
      end

      WAIT_DATA: begin
        stall = 1'b1;
        if (restore_en_i) begin
          capture = 1'b1;
          slot_d  = '0;
          timer_d = '0;
          state_d = WRITE;
        end else if (timer_q == TimerW'(RestoreTimeout - 1)) begin
          // The LIFO never answered; give up. Depth stays decremented.
          err     = 1'b1;
          timer_d = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end

      WRITE: begin
        stall = 1'b1;
        we    = 1'b1;
        waddr = slot_addr_tbl[slot_q];
        wdata = buf_q[slot_q];
        // A second context while draining is a protocol error; ignore it.
        if (restore_en_i) begin
          err = 1'b1;
        end
        // Without a grant the slot, address and data stay put.
        if (rf_wgnt_i) begin
          if (slot_q == SlotW'(NrSavedRegs - 1)) begin
            slot_d  = '0;
            state_d = DONE;
          end else begin
            slot_d = slot_q + SlotW'(1);
          end
        end
      end

      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      depth_q <= '0;
      slot_q  <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      slot_q  <= slot_d;
      timer_q <= timer_d;
    end
  end

  // Capture the full context word when the LIFO presents it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q <= '0;
    end else if (capture) begin
      buf_q <= restore_data_i;
    end
  end

  // Outputs are forced low while reset is held so an abort is visible at once,
  // even though the pulse flags decode straight from the inputs.
  assign stall_o     = stall & rst_ni;
  assign rf_we_o     = we & rst_ni;
  assign rf_waddr_o  = rst_ni ? waddr : 5'd0;
  assign rf_wdata_o  = rst_ni ? wdata : '0;
  assign done_o      = done & rst_ni;
  assign err_o       = err & rst_ni;
  assign overflow_o  = overflow & rst_ni;
  assign underflow_o = underflow & rst_ni;
  assign depth_o     = depth_q;

endmodule
`default_nettype wire

// File: tb/tb_rt_ibex_pcs_rf_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_rt_ibex_pcs_rf_writeback
// Brief    : Scoreboard bench for the PCS register-file write-back block.
//            Stimulus queues expected events tagged with their cycle; a
//            negedge monitor matches every DUT pulse and value check.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rt_ibex_pcs_rf_writeback;

  typedef struct {
    int          kind;  // 0 write,1 done,2 err,3 overflow,4 underflow,5 depth,6 stall
    int          cyc;
    logic [31:0] a;
    logic [31:0] d;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_ni;
  logic            irq_ack;
  logic            next_mret;
  logic            restore_en;
  logic [8:0][31:0] rdata;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [31:0]     rf_wdata;
  logic            rf_wgnt;
  logic            stall;
  logic            done;
  logic [3:0]      depth;
  logic            overflow;
  logic            underflow;
  logic            err;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic end_chk = 1'b0;
  exp_t q[$];
  exp_t keep[$];
  logic got [0:4];
  logic held_seen;

  logic [4:0] addr_tbl [9] = '{5'd1, 5'd5, 5'd6, 5'd7, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14};
  string      ev_name  [5] = '{"write", "done", "err", "overflow", "underflow"};

  rt_ibex_pcs_rf_writeback dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .irq_ack_i     (irq_ack),
    .next_mret_i   (next_mret),
    .restore_en_i  (restore_en),
    .restore_data_i(rdata),
    .rf_we_o       (rf_we),
    .rf_waddr_o    (rf_waddr),
    .rf_wdata_o    (rf_wdata),
    .rf_wgnt_i     (rf_wgnt),
    .stall_o       (stall),
    .done_o        (done),
    .depth_o       (depth),
    .overflow_o    (overflow),
    .underflow_o   (underflow),
    .err_o         (err)
  );

  always #5 clk = ~clk;

  // Cycle index used to tag expectations.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: consume every expectation due this cycle and flag stray pulses.
  always @(negedge clk) begin
    got[0] = rf_we & rf_wgnt;
    got[1] = done;
    got[2] = err;
    got[3] = overflow;
    got[4] = underflow;
    keep = {};
    foreach (q[i]) begin
      if (q[i].cyc == cyc) begin
        checks++;
        case (q[i].kind)
          5: if (depth !== q[i].d[3:0]) begin
               errors++;
               $display("FAIL depth cyc=%0d got=%0d want=%0d", cyc, depth, q[i].d[3:0]);
             end
          6: if (stall !== q[i].d[0]) begin
               errors++;
               $display("FAIL stall cyc=%0d got=%0b want=%0b", cyc, stall, q[i].d[0]);
             end
          default: begin
            if (!got[q[i].kind]) begin
              errors++;
              $display("FAIL missing %s cyc=%0d got=0 want=1", ev_name[q[i].kind], cyc);
            end else begin
              got[q[i].kind] = 1'b0;
              if (q[i].kind == 0 && (rf_waddr !== q[i].a[4:0] || rf_wdata !== q[i].d)) begin
                errors++;
                $display("FAIL write cyc=%0d got x%0d=%h want x%0d=%h",
                         cyc, rf_waddr, rf_wdata, q[i].a[4:0], q[i].d);
              end
            end
          end
        endcase
      end else begin
        keep.push_back(q[i]);
      end
    end
    for (int k = 0; k < 5; k++) begin
      if (got[k]) begin
        checks++;
        errors++;
        $display("FAIL unexpected %s cyc=%0d got=1 want=0", ev_name[k], cyc);
      end
    end
    // A stalled write must keep presenting the next expected slot.
    if (rf_we && !rf_wgnt) begin
      held_seen = 1'b0;
      foreach (keep[i]) begin
        if (!held_seen && keep[i].kind == 0) begin
          held_seen = 1'b1;
          checks++;
          if (rf_waddr !== keep[i].a[4:0] || rf_wdata !== keep[i].d) begin
            errors++;
            $display("FAIL held_write cyc=%0d got x%0d=%h want x%0d=%h",
                     cyc, rf_waddr, rf_wdata, keep[i].a[4:0], keep[i].d);
          end
        end
      end
    end
    q = keep;
    if (end_chk) begin
      checks++;
      if (q.size() != 0) begin
        errors++;
        $display("FAIL leftover_expectations got=%0d want=0", q.size());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int kind, input int c, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.kind = kind;
    e.cyc  = c;
    e.a    = a;
    e.d    = d;
    q.push_back(e);
  endtask

  task automatic clear_inputs();
    irq_ack    = 1'b0;
    next_mret  = 1'b0;
    restore_en = 1'b0;
    rf_wgnt    = 1'b1;
    rdata      = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_ni = 1'b0;
    push(5, cyc, 0, 0);
    push(6, cyc, 0, 0);
    tick();
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic acks(input int n);
    for (int i = 0; i < n; i++) begin
      irq_ack = 1'b1;
      tick();
    end
    irq_ack = 1'b0;
  endtask

  // mret at relative cycle 0, context at cycle 2, grants low in [gs, gs+gl).
  // Optional: ack at ack_k, stray restore_en at re_k, reset at abort_k.
  task automatic run_restore(input int done_off, input int gs, input int gl,
                             input int ack_k, input int re_k, input int abort_k);
    int t0;
    int s;
    int last;
    t0 = cyc;
    s  = 0;
    for (int k = 3; k < 40 && s < 9; k++) begin
      if (abort_k >= 0 && k >= abort_k) break;
      if (!(k >= gs && k < gs + gl)) begin
        push(0, t0 + k, {27'd0, addr_tbl[s]}, 32'hA000_0000 + 32'(s));
        s++;
      end
    end
    if (abort_k < 0) push(1, t0 + done_off, 0, 0);
    if (re_k >= 0) push(2, t0 + re_k, 0, 0);
    last = (abort_k >= 0) ? abort_k : done_off;
    for (int k = 0; k <= last; k++) begin
      next_mret  = (k == 0);
      irq_ack    = (k == ack_k);
      restore_en = (k == 2) || (k == re_k);
      for (int j = 0; j < 9; j++) begin
        rdata[j] = (k == 2) ? 32'hA000_0000 + 32'(j) : 32'hDEAD_0000 + 32'(j);
      end
      rf_wgnt = !(k >= gs && k < gs + gl);
      if (abort_k >= 0 && k == abort_k) begin
        rst_ni = 1'b0;
        push(5, t0 + k, 0, 0);
      end
      push(6, t0 + k, 0, (k < last) ? 32'd1 : 32'd0);
      tick();
    end
    clear_inputs();
  endtask

  task automatic mret_underflow();
    next_mret = 1'b1;
    push(4, cyc, 0, 0);
    push(6, cyc, 0, 0);
    tick();
    next_mret = 1'b0;
  endtask

  initial begin
    int t0;
    clear_inputs();
    rst_ni = 1'b0;
    tick();
    do_reset();

    // Nominal restore: done at cycle 12, depth 3 -> 2.
    acks(3);
    push(5, cyc, 0, 3);
    run_restore(12, -1, 0, -1, -1, -1);
    push(5, cyc, 0, 2);
    tick();

    // Grant withheld in cycles 4..6: slot 1 held, done at cycle 15.
    run_restore(15, 4, 3, -1, -1, -1);
    push(5, cyc, 0, 1);
    tick();

    // Drain to zero, then underflow, then overflow on the 9th ack.
    run_restore(12, -1, 0, -1, -1, -1);
    push(5, cyc, 0, 0);
    tick();
    mret_underflow();
    push(5, cyc, 0, 0);
    acks(8);
    irq_ack = 1'b1;
    push(3, cyc, 0, 0);
    tick();
    irq_ack = 1'b0;
    push(5, cyc, 0, 8);
    tick();

    // Restore timeout: err in the 4th WAIT_DATA cycle, depth 8 -> 7.
    t0 = cyc;
    push(2, t0 + 4, 0, 0);
    for (int k = 0; k <= 5; k++) begin
      next_mret = (k == 0);
      push(6, t0 + k, 0, (k < 5) ? 32'd1 : 32'd0);
      if (k == 5) push(5, t0 + k, 0, 7);
      tick();
    end
    clear_inputs();

    // Ack beats mret in the same cycle; then ack and stray data mid-WRITE.
    do_reset();
    acks(2);
    irq_ack   = 1'b1;
    next_mret = 1'b1;
    push(6, cyc, 0, 0);
    tick();
    clear_inputs();
    push(5, cyc, 0, 3);
    push(6, cyc, 0, 0);
    tick();
    run_restore(12, -1, 0, 5, 6, -1);
    push(5, cyc, 0, 3);
    tick();

    // Stray context in IDLE is dropped with an error.
    restore_en = 1'b1;
    rdata      = '1;
    push(2, cyc, 0, 0);
    push(6, cyc, 0, 0);
    tick();
    clear_inputs();

    // Reset during WRITE at slot 4 aborts everything.
    acks(2);
    run_restore(0, -1, 0, -1, -1, 7);
    tick();
    rst_ni = 1'b1;
    tick();
    mret_underflow();
    push(5, cyc, 0, 0);
    tick();
    tick();

    end_chk = 1'b1;
    tick();
    end_chk = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/rt_ibex_pcs_rf_writeback.md
Name: rt_ibex_pcs_rf_writeback

Overview:
Downstream consumer of the PCS context LIFO. On each mret it captures the restored context word and writes the saved registers back into the Ibex register file one at a time over a dedicated write port, stalling the core until the write-back finishes. It also keeps the nesting-depth count of saved contexts and reports overflow, underflow and protocol errors.

Parameters:
NrSavedRegs, 9, number of saved registers per context (slots 0..NrSavedRegs-1).
DataWidth, 32, register width.
MaxDepth, 8, LIFO capacity in contexts; must match the LIFO depth.
SlotAddr, {x1,x5,x6,x7,x10,x11,x12,x13,x14}, slot i maps to RF address SlotAddr[i] (5 b each); slot 0 = x1.
RestoreTimeout, 4, maximum cycles in WAIT_DATA before an error is raised.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset
irq_ack_i  in  1  interrupt accepted; one context is pushed
next_mret_i  in  1  mret is about to retire; one context is popped
restore_en_i  in  1  restore_data_i is valid this cycle
restore_data_i  in  NrSavedRegs x DataWidth  context from the LIFO; slot i = element i
rf_we_o  out  1  RF write request
rf_waddr_o  out  5  RF write address
rf_wdata_o  out  DataWidth  RF write data
rf_wgnt_i  in  1  RF write accepted this cycle (core writeback has priority)
stall_o  out  1  hold the core pipeline
done_o  out  1  one-cycle pulse when the restore completes
depth_o  out  $clog2(MaxDepth+1)  number of contexts currently saved
overflow_o  out  1  pulse
underflow_o  out  1  pulse
err_o  out  1  pulse

Behaviour:
- Reset is asynchronous, active-low rst_ni; clock is clk_i. On reset: FSM = IDLE, depth = 0, slot counter = 0, capture buffer = 0, all outputs 0.
- Depth counter:
  - irq_ack_i: +1.
  - Accepted mret: −1.
  - irq_ack_i with depth == MaxDepth: overflow_o pulses for 1 cycle and depth holds.
  - irq_ack_i is counted in every FSM state.
- Mret acceptance: in IDLE only, requires next_mret_i = 1, irq_ack_i = 0 and depth > 0.
  - If irq_ack_i and next_mret_i are both high, the ack wins and the mret is not accepted (same priority as the LIFO).
  - next_mret_i with depth == 0: underflow_o pulses, FSM stays in IDLE, no stall.
  - next_mret_i outside IDLE is ignored.
- FSM states:
  - IDLE:
    - Accepted mret → WAIT_DATA; stall_o = 1 combinationally in that same cycle.
    - restore_en_i in IDLE → err_o pulse, data dropped.
  - WAIT_DATA:
    - stall_o = 1; a timeout counter counts from 0.
    - restore_en_i → capture the whole restore_data_i into the buffer, set slot = 0, go to WRITE.
    - If RestoreTimeout cycles elapse without restore_en_i → err_o pulse, go to IDLE; depth stays decremented.
  - WRITE:
    - stall_o = 1, rf_we_o = 1, rf_waddr_o = SlotAddr[slot], rf_wdata_o = buffer[slot].
    - rf_wgnt_i = 1 advances the slot; rf_wgnt_i = 0 holds the slot and keeps address and data stable.
    - Grant on slot NrSavedRegs−1 → DONE.
    - restore_en_i here → err_o pulse and it is ignored.
  - DONE: done_o = 1, stall_o = 0, rf_we_o = 0, then go to IDLE. Mret is not accepted in DONE.
- Nominal latency with continuous grants:
  - mret at cycle 0; WAIT_DATA in cycles 1–2; restore_en_i at cycle 2.
  - WRITE in cycles 3–11; done_o at cycle 12.
  - stall_o high in cycles 0–11.
- rf_we_o, rf_waddr_o and rf_wdata_o are 0 outside WRITE.
- Reset asserted mid-operation aborts immediately: no partial write continues and depth = 0.

Test Plan:
- Reset, then irq_ack ×3 → depth_o = 3. mret; restore_en_i at cycle 2 with slot i = 0xA000_0000+i → RF writes x1 = 0xA0000000 … x14 = 0xA0000008 in cycles 3–11, done_o at cycle 12, depth_o = 2.
- Same as the first scenario but rf_wgnt_i low in cycles 4–6 → slot 1 (x5, 0xA0000001) held stable for 4 cycles, done_o at cycle 15, stall_o high until cycle 14.
- depth = 0, next_mret_i → underflow_o pulse, stall_o stays 0, no rf_we_o. irq_ack ×9 with MaxDepth = 8 → one overflow_o pulse, depth_o = 8.
- mret accepted, restore_en_i never arrives → err_o pulse after 4 cycles in WAIT_DATA, FSM back in IDLE, stall_o low, depth decremented.
- irq_ack_i and next_mret_i in the same IDLE cycle with depth = 2 → depth_o = 3, FSM stays in IDLE. irq_ack_i during WRITE → depth increments and the write sequence is undisturbed.
- rst_ni pulsed low during WRITE at slot 4 → all outputs 0 immediately, depth_o = 0, FSM in IDLE; the next mret raises underflow_o.
